add_16: RTL and testbench

- 16-bit binary adder with carry-in and carry-out. Operands and sum are unsigned; signed overflow is available only through the optional feature.
- Sum and carry are registered on the rising clock edge, giving a one-cycle latency.
- Internally built from four 4-bit carry-lookahead groups, joined by a second-level lookahead unit.
- Used as the arithmetic leaf in datapaths that need a timed 16-bit add.

---
 rtl/add_16.sv | 108 ++++++++++
 tb/tb_add_16.sv | 135 +++++++++++++
 2 files changed

// File: rtl/add_16.sv
// Registered 16-bit adder: four 4-bit CLA groups joined by a second-level lookahead unit.
// Define ADD16_FLAGS_EN to add registered signed-overflow (V) and zero (Z) flags.
module add_16_cla4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] c,
    output logic       gg,
    output logic       gp
);
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
endmodule

module add_16_lcu (
    input  logic [3:0] gg,
    input  logic [3:0] gp,
    input  logic       ci,
    output logic       c4,
    output logic       c8,
    output logic       c12,
    output logic       c16
);
    assign c4  = gg[0] | (gp[0] & ci);
    assign c8  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    assign c12 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & ci);
    assign c16 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
endmodule

module add_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
`ifdef ADD16_FLAGS_EN
    output logic        V,
    output logic        Z,
`endif
    output logic [15:0] S,
    output logic        C_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [15:0] sum;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic        c16;

    assign p = A ^ B;
    assign g = A & B;

    for (genvar i = 0; i < 4; i++) begin : grp
        add_16_cla4 u_cla (
            .p  (p[4*i +: 4]),
            .g  (g[4*i +: 4]),
            .ci (gc[i]),
            .c  (c[4*i +: 4]),
            .gg (gg[i]),
            .gp (gp[i])
        );
    end

    assign gc[0] = C_in;

    add_16_lcu u_lcu (
        .gg  (gg),
        .gp  (gp),
        .ci  (C_in),
        .c4  (gc[1]),
        .c8  (gc[2]),
        .c12 (gc[3]),
        .c16 (c16)
    );

    assign sum = p ^ c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S     <= '0;
            C_out <= 1'b0;
`ifdef ADD16_FLAGS_EN
            V     <= 1'b0;
            Z     <= 1'b0;
`endif
        end else begin
            S     <= sum;
            C_out <= c16;
`ifdef ADD16_FLAGS_EN
            // c[15] is the carry into the sign bit
            V     <= c16 ^ c[15];
            Z     <= (sum == 16'h0000);
`endif
        end
    end
endmodule

// File: tb/tb_add_16.sv
// Scoreboard bench for add_16: driver queues expected results, monitor checks them.
module tb_add_16;
    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        C_in;
    logic [15:0] S;
    logic        C_out;
`ifdef ADD16_FLAGS_EN
    logic        V;
    logic        Z;
`endif

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    bit   have_last;
    int   vectors;
    int   miscompares;

    add_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C_in  (C_in),
`ifdef ADD16_FLAGS_EN
        .V     (V),
        .Z     (Z),
`endif
        .S     (S),
        .C_out (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(bit rst, int unsigned a, int unsigned b,
                                   int unsigned ci);
        exp_t e;
        int unsigned total;
        int ssum;
        e = '{s: 16'h0, c: 1'b0, v: 1'b0, z: 1'b0};
        if (rst) begin
            total = a + b + ci;
            e.s = total[15:0];
            e.c = (total > 32'hFFFF);
            ssum = ((a >= 32768) ? int'(a) - 65536 : int'(a))
                 + ((b >= 32768) ? int'(b) - 65536 : int'(b)) + int'(ci);
            e.v = (ssum > 32767) || (ssum < -32768);
            e.z = (e.s == 16'h0);
        end
        return e;
    endfunction

    task automatic step(bit r, logic [15:0] a, logic [15:0] b, logic ci);
        rst_n = r;
        A = a;
        B = b;
        C_in = ci;
        exp_q.push_back(model(r, a, b, ci));
        @(negedge clk);
    endtask

    task automatic check(string nm, exp_t e);
        bit bad;
        vectors++;
        bad = (S !== e.s) || (C_out !== e.c);
`ifdef ADD16_FLAGS_EN
        bad = bad || (V !== e.v) || (Z !== e.z);
        if (bad)
            $display("FAIL %s: got S=%h C=%b V=%b Z=%b, want S=%h C=%b V=%b Z=%b",
                     nm, S, C_out, V, Z, e.s, e.c, e.v, e.z);
`else
        if (bad)
            $display("FAIL %s: got S=%h C=%b, want S=%h C=%b",
                     nm, S, C_out, e.s, e.c);
`endif
        if (bad) miscompares++;
    endtask

    // Monitor: check each registered result just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            last = exp_q.pop_front();
            have_last = 1'b1;
            check("result", last);
        end
    end

    // Outputs must not follow the inputs driven at the falling edge
    always @(negedge clk) begin
        #1;
        if (have_last) check("hold", last);
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        have_last = 1'b0;
        step(1'b0, 16'h1234, 16'h1111, 1'b1);
        step(1'b0, 16'h1234, 16'h1111, 1'b1);
        step(1'b1, 16'h1234, 16'h1111, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step(1'b1, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 16'h8000, 16'h8000, 1'b0);
        step(1'b1, 16'hAAAA, 16'h5555, 1'b1);
        step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        step(1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
        step(1'b1, 16'h00FF, 16'h0001, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 64) != 0, 16'($urandom), 16'($urandom),
                 1'($urandom));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d results pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
